// File: rtl/rx_quadro_cmd.sv
// Command-frame decoder behind the UART receiver: acks each byte and assembles
// AA/cmd/dado/chk frames, with valid/accept output and one-cycle error pulses.
module rx_quadro_cmd #(
  parameter logic [7:0]  CABECALHO     = 8'hAA,
  parameter logic [15:0] TIMEOUT_TICKS = 16'd480
) (
  input  logic       clock,
  input  logic       reinicia,
  input  logic       tick,
  input  logic       rdy_rx,
  input  logic [7:0] dado_rx,
  output logic       limpa_rx,
  output logic [7:0] cmd,
  output logic [7:0] dado,
  output logic       valido,
  input  logic       aceito,
  output logic       erro_checksum,
  output logic       erro_timeout,
  output logic       sobrecarga
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    ESPERA_CAB,
    RX_CMD,
    RX_DADO,
    RX_CHK,
    SAIDA
  } estado_t;

  estado_t           estado, estado_n;
  logic              rdy_q, primeiro_q;
  logic [CNT_W-1:0]  cnt, cnt_n, cnt_inc;
  logic [BYTE_W-1:0] cmd_int, cmd_int_n, dado_int, dado_int_n, cmd_n, dado_n;
  logic              valido_n, chk_n, to_n, ovr_n;
  logic              captura_c;

  // A byte is new only on the rising edge of the sticky ready.
  assign captura_c = rdy_rx & ~rdy_q;
  assign cnt_inc   = (tick && cnt != '1) ? CNT_W'(cnt + CNT_W'(1)) : cnt;

  always_ff @(posedge clock) begin
    if (reinicia) begin
      estado        <= ESPERA_CAB;
      rdy_q         <= 1'b1;
      primeiro_q    <= 1'b1;
      cnt           <= '0;
      cmd_int       <= '0;
      dado_int      <= '0;
      cmd           <= '0;
      dado          <= '0;
      valido        <= 1'b0;
      limpa_rx      <= 1'b0;
      erro_checksum <= 1'b0;
      erro_timeout  <= 1'b0;
      sobrecarga    <= 1'b0;
    end else begin
      estado        <= estado_n;
      rdy_q         <= rdy_rx;
      primeiro_q    <= 1'b0;
      cnt           <= cnt_n;
      cmd_int       <= cmd_int_n;
      dado_int      <= dado_int_n;
      cmd           <= cmd_n;
      dado          <= dado_n;
      valido        <= valido_n;
      // A byte left pending across reset is acked once but never decoded.
      limpa_rx      <= captura_c | (primeiro_q & rdy_rx);
      erro_checksum <= chk_n;
      erro_timeout  <= to_n;
      sobrecarga    <= ovr_n;
    end
  end

  always_comb begin
    estado_n   = estado;
    cnt_n      = '0;
    cmd_int_n  = cmd_int;
    dado_int_n = dado_int;
    cmd_n      = cmd;
    dado_n     = dado;
    valido_n   = valido;
    chk_n      = 1'b0;
    to_n       = 1'b0;
    ovr_n      = 1'b0;
    case (estado)
      ESPERA_CAB: begin
        if (captura_c && dado_rx == CABECALHO) estado_n = RX_CMD;
      end
      RX_CMD, RX_DADO, RX_CHK: begin
        // Capture beats a simultaneous timeout.
        if (captura_c) begin
          case (estado)
            RX_CMD: begin
              cmd_int_n = dado_rx;
              estado_n  = RX_DADO;
            end
            RX_DADO: begin
              dado_int_n = dado_rx;
              estado_n   = RX_CHK;
            end
            default: begin
              if (dado_rx == (cmd_int ^ dado_int)) begin
                cmd_n    = cmd_int;
                dado_n   = dado_int;
                valido_n = 1'b1;
                estado_n = SAIDA;
              end else begin
                chk_n    = 1'b1;
                estado_n = ESPERA_CAB;
              end
            end
          endcase
        end else if (cnt_inc >= TIMEOUT_TICKS) begin
          to_n     = 1'b1;
          estado_n = ESPERA_CAB;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      SAIDA: begin
        if (aceito) begin
          valido_n = 1'b0;
          estado_n = (captura_c && dado_rx == CABECALHO) ? RX_CMD : ESPERA_CAB;
        end else if (captura_c) begin
          ovr_n = 1'b1;
        end
      end
      default: estado_n = ESPERA_CAB;
    endcase
  end

endmodule

// File: tb/tb_rx_quadro_cmd.sv
// Scoreboard bench for rx_quadro_cmd: directed byte streams push expected
// events; a negedge monitor pops and compares whenever the DUT reports one.
module tb_rx_quadro_cmd;

  localparam logic [1:0] K_FRAME = 2'd0;
  localparam logic [1:0] K_CHK   = 2'd1;
  localparam logic [1:0] K_TO    = 2'd2;
  localparam logic [1:0] K_OVR   = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] c;
    logic [7:0] d;
  } ev_t;

  logic       clock = 1'b0;
  logic       reinicia = 1'b1;
  logic       tick = 1'b0;
  logic       rdy_rx = 1'b0;
  logic [7:0] dado_rx = 8'h00;
  logic       aceito = 1'b0;
  logic       limpa_rx, valido, erro_checksum, erro_timeout, sobrecarga;
  logic [7:0] cmd, dado;

  ev_t  q[$];
  int   total = 0;
  int   passed = 0;
  int   limpa_cnt = 0;
  int   exp_limpa = 0;
  logic valido_d = 1'b0;

  rx_quadro_cmd dut (
    .clock(clock), .reinicia(reinicia), .tick(tick), .rdy_rx(rdy_rx),
    .dado_rx(dado_rx), .limpa_rx(limpa_rx), .cmd(cmd), .dado(dado),
    .valido(valido), .aceito(aceito), .erro_checksum(erro_checksum),
    .erro_timeout(erro_timeout), .sobrecarga(sobrecarga)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time expired, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic expect_ev(input logic [1:0] k, input logic [7:0] c, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.c    = c;
    e.d    = d;
    q.push_back(e);
  endtask

  task automatic got(input logic [1:0] k);
    ev_t e;
    if (q.size() == 0) begin
      total++;
      $display("FAIL unexpected_event: got kind %0d, required none", k);
    end else begin
      e = q.pop_front();
      check("event_kind", 32'(k), 32'(e.kind));
      if (k == K_FRAME || k == K_OVR) begin
        check("event_cmd", 32'(cmd), 32'(e.c));
        check("event_dado", 32'(dado), 32'(e.d));
      end
    end
  endtask

  // Monitor: every DUT-reported event is matched against the scoreboard.
  always @(negedge clock) begin
    if (!reinicia) begin
      if (valido && !valido_d) got(K_FRAME);
      if (erro_checksum) got(K_CHK);
      if (erro_timeout) got(K_TO);
      if (sobrecarga) got(K_OVR);
      if (limpa_rx) limpa_cnt++;
    end
    valido_d = valido;
  end

  // Receiver model: raise sticky ready, drop it once limpa_rx is seen.
  task automatic send_byte(input logic [7:0] b, input logic acc);
    logic ok;
    ok = 1'b0;
    @(negedge clock);
    dado_rx = b;
    rdy_rx  = 1'b1;
    aceito  = acc;
    exp_limpa++;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      aceito = 1'b0;
      if (limpa_rx) begin
        ok = 1'b1;
        break;
      end
    end
    rdy_rx = 1'b0;
    check("byte_acked", 32'(ok), 32'd1);
    repeat (2) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] d, input logic [7:0] k);
    send_byte(8'hAA, 1'b0);
    send_byte(c, 1'b0);
    send_byte(d, 1'b0);
    send_byte(k, 1'b0);
  endtask

  task automatic accept();
    @(negedge clock);
    check("valido_before_accept", 32'(valido), 32'd1);
    aceito = 1'b1;
    @(negedge clock);
    aceito = 1'b0;
    check("valido_after_accept", 32'(valido), 32'd0);
  endtask

  initial begin
    logic ok;
    repeat (3) @(negedge clock);
    check("reset_outputs", 32'({limpa_rx, valido, erro_checksum, erro_timeout, sobrecarga, cmd, dado}), 32'd0);
    reinicia = 1'b0;
    repeat (2) @(negedge clock);

    // Good frame
    expect_ev(K_FRAME, 8'h12, 8'h34);
    send_frame(8'h12, 8'h34, 8'h26);
    check("t1_limpa_count", 32'(limpa_cnt), 32'd4);
    accept();

    // Bad checksum, then a good frame
    expect_ev(K_CHK, 8'h00, 8'h00);
    send_frame(8'h12, 8'h34, 8'h00);
    check("t2_valido_low", 32'(valido), 32'd0);
    expect_ev(K_FRAME, 8'h01, 8'h02);
    send_frame(8'h01, 8'h02, 8'h03);
    accept();

    // Junk byte dropped, frame decodes; then accept and header on one edge
    send_byte(8'h55, 1'b0);
    expect_ev(K_FRAME, 8'h5A, 8'hA5);
    send_frame(8'h5A, 8'hA5, 8'hFF);
    send_byte(8'hAA, 1'b1);
    check("same_edge_valido", 32'(valido), 32'd0);
    expect_ev(K_FRAME, 8'h07, 8'h70);
    send_byte(8'h07, 1'b0);
    send_byte(8'h70, 1'b0);
    send_byte(8'h77, 1'b0);
    accept();

    // Timeout exactly at tick 480
    send_byte(8'hAA, 1'b0);
    send_byte(8'h12, 1'b0);
    for (int i = 0; i < 479; i++) begin
      @(negedge clock); tick = 1'b1;
      @(negedge clock); tick = 1'b0;
    end
    expect_ev(K_TO, 8'h00, 8'h00);
    @(negedge clock); tick = 1'b1;
    @(negedge clock); tick = 1'b0;
    repeat (2) @(negedge clock);
    check("t4_timeout_seen", 32'(q.size()), 32'd0);
    expect_ev(K_FRAME, 8'h12, 8'h34);
    send_frame(8'h12, 8'h34, 8'h26);

    // Overrun while holding a frame
    expect_ev(K_OVR, 8'h12, 8'h34);
    send_byte(8'hAA, 1'b0);
    check("t5_cmd_held", 32'(cmd), 32'h12);
    check("t5_dado_held", 32'(dado), 32'h34);
    accept();

    // Reset mid-frame with a stale header pending
    send_byte(8'hAA, 1'b0);
    send_byte(8'h12, 1'b0);
    @(negedge clock);
    reinicia = 1'b1;
    dado_rx  = 8'hAA;
    rdy_rx   = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("t6_reset_outputs", 32'({limpa_rx, valido, erro_checksum, erro_timeout, sobrecarga, cmd, dado}), 32'd0);
    reinicia = 1'b0;
    exp_limpa++;
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (limpa_rx) begin
        ok = 1'b1;
        break;
      end
    end
    rdy_rx = 1'b0;
    check("t6_stale_acked", 32'(ok), 32'd1);
    repeat (3) @(negedge clock);
    expect_ev(K_FRAME, 8'h12, 8'h34);
    send_frame(8'h12, 8'h34, 8'h26);
    accept();

    repeat (5) @(negedge clock);
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    check("limpa_total", 32'(limpa_cnt), 32'(exp_limpa));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
